// File: rtl/rf_writeback_unit_pkg.sv
// Shared definitions for the register-file write-back front end.
//   XLEN       : result / write-port data width
//   REG_ADDR_W : architectural register address width
//   LQ_DEPTH   : memory-result queue depth, also the limit on outstanding long ops
//   wb_entry_t : one queued memory result {rd, data}
package rv_wb_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int LQ_DEPTH   = 4;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/rf_writeback_unit_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t holding memory results until the
// register-file write port is free.
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset (empties the FIFO)
//   push, push_entry   : enqueue request and entry (ignored when full)
//   pop                : dequeue request (ignored when empty)
//   head               : oldest entry, valid while !empty
//   full, empty        : occupancy flags
module wb_fifo
   import rv_wb_pkg::*;
#(
   parameter int DEPTH = LQ_DEPTH
) (
   input  logic      clk,
   input  logic      reset_n,
   input  logic      push,
   input  wb_entry_t push_entry,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int PW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   wb_entry_t   mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[PW-1:0]] <= push_entry;
   end

endmodule

// File: rtl/rf_writeback_unit.sv
// rf_writeback_unit: merges ALU results and queued memory results onto the
// register file's single write port and tracks registers with outstanding
// long-latency writes.
// Ports:
//   clk, reset_n                  : clock, synchronous active-low reset
//   issue_valid/rd/long, issue_stall : decode issue and its stall (comb)
//   q_a1/q_a2, busy1/busy2        : decode read addresses and hazard flags (comb)
//   alu_valid/rd/data             : single-cycle result, always wins the port
//   mem_valid/rd/data, mem_ready  : memory result handshake into the queue
//   rf_a3/rf_wd/rf_wen            : registered register-file write port
// The queue entry type comes from rv_wb_pkg, so XLEN and REG_ADDR_W must
// match the package values.
module rf_writeback_unit
   import rv_wb_pkg::*;
#(
   parameter int XLEN       = rv_wb_pkg::XLEN,
   parameter int REG_ADDR_W = rv_wb_pkg::REG_ADDR_W,
   parameter int LQ_DEPTH   = rv_wb_pkg::LQ_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  issue_long,
   output logic                  issue_stall,
   input  logic [REG_ADDR_W-1:0] q_a1,
   input  logic [REG_ADDR_W-1:0] q_a2,
   output logic                  busy1,
   output logic                  busy2,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_data,
   output logic [REG_ADDR_W-1:0] rf_a3,
   output logic [XLEN-1:0]       rf_wd,
   output logic                  rf_wen
);

   localparam int NREG  = 2**REG_ADDR_W;
   localparam int CNT_W = $clog2(LQ_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LQ_DEPTH);

   logic [NREG-1:0]  busy_vec;
   logic [NREG-1:0]  busy_nxt;
   logic [CNT_W-1:0] outstanding;

   wb_entry_t q_head;
   wb_entry_t q_in;
   logic      q_full;
   logic      q_empty;
   logic      q_push;
   logic      q_pop;
   logic      long_acc;

   assign issue_stall = issue_valid &&
                        (((issue_rd != '0) && busy_vec[issue_rd]) ||
                         (issue_long && (outstanding == CNT_MAX)));

   assign long_acc  = issue_valid && issue_long && !issue_stall && (issue_rd != '0);
   assign mem_ready = reset_n && !q_full;
   assign q_push    = mem_valid && mem_ready;
   // The queue only drains on cycles the ALU leaves the write port idle.
   assign q_pop     = !alu_valid && !q_empty;

   assign q_in.rd   = mem_rd;
   assign q_in.data = mem_data;

   assign busy1 = (q_a1 != '0) && busy_vec[q_a1];
   assign busy2 = (q_a2 != '0) && busy_vec[q_a2];

   wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (q_push),
      .push_entry (q_in),
      .pop        (q_pop),
      .head       (q_head),
      .full       (q_full),
      .empty      (q_empty)
   );

   // Set is applied after clear so a same-edge set of the popped register wins.
   always_comb begin
      busy_nxt = busy_vec;
      if (q_pop)    busy_nxt[q_head.rd] = 1'b0;
      if (long_acc) busy_nxt[issue_rd]  = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy_vec    <= '0;
         outstanding <= '0;
         rf_a3       <= '0;
         rf_wd       <= '0;
         rf_wen      <= 1'b0;
      end else begin
         busy_vec <= busy_nxt;

         if (long_acc && !q_pop && (outstanding != CNT_MAX))
            outstanding <= outstanding + 1'b1;
         else if (q_pop && !long_acc && (outstanding != '0))
            outstanding <= outstanding - 1'b1;

         if (alu_valid) begin
            rf_a3  <= alu_rd;
            rf_wd  <= alu_data;
            rf_wen <= (alu_rd != '0);
         end else if (q_pop) begin
            rf_a3  <= q_head.rd;
            rf_wd  <= q_head.data;
            rf_wen <= (q_head.rd != '0);
         end else begin
            rf_wen <= 1'b0;
         end
      end
   end

endmodule
